// File: rtl/sys_defs.sv
// Shared system definitions for the dispatch path.
// Contents:
//   N_WAY_DEFAULT    - superscalar width used by default (lanes per cycle)
//   IQ_DEPTH_DEFAULT - instruction-queue depth used by default (power of two)
//   DISPATCH_PACKET  - decoded instruction as handed from decode to rename/ROB
//   IQ_ENTRY         - one dispatch-queue slot: packet plus its branch flag
package sys_defs;

   localparam int N_WAY_DEFAULT    = 2;
   localparam int IQ_DEPTH_DEFAULT = 8;

   typedef struct packed {
      logic        valid;
      logic [31:0] pc;
      logic [31:0] inst;
      logic [4:0]  dest_reg;
   } DISPATCH_PACKET;

   typedef struct packed {
      DISPATCH_PACKET pkt;
      logic           branch;
   } IQ_ENTRY;

endpackage

// File: rtl/lsb_ones_count.sv
// Counts the run of consecutive 1s starting at bit 0 of bits_i.
// Ports:
//   bits_i  [N-1:0]         input vector
//   count_o [$clog2(N):0]   length of the unbroken run of 1s from bit 0
module lsb_ones_count #(
   parameter int N = 2
) (
   input  logic [N-1:0]       bits_i,
   output logic [$clog2(N):0] count_o
);

   localparam int CW = $clog2(N) + 1;

   logic run;

   always_comb begin
      count_o = '0;
      run     = 1'b1;
      for (int i = 0; i < N; i++) begin
         // Once a 0 is seen, later 1s no longer extend the run.
         run = run & bits_i[i];
         if (run) begin
            count_o = count_o + CW'(1);
         end
      end
   end

endmodule

// File: rtl/dispatch_queue.sv
// In-order instruction buffer between decode/fetch and rename/ROB.
// Ports:
//   clock            sole clock, rising edge
//   reset            asynchronous active-low reset
//   fetch_packet     decoded instructions in, lane 0 oldest
//   fetch_branch     per-lane branch flag for fetch_packet
//   fetch_ready      room for a full N_WAY group (independent of same-cycle pop)
//   dispatch_packet  oldest N_WAY queued instructions, lane 0 oldest
//   branch_inst      branch flag aligned with dispatch_packet
//   dispatch_num     number of valid lanes presented
//   dispatched       per-lane acceptance from rename/ROB
//   branch_haz       mispredict flush; empties the queue at the edge
//   iq_count         occupied entries
module dispatch_queue
   import sys_defs::*;
#(
   parameter int N_WAY    = N_WAY_DEFAULT,
   parameter int IQ_DEPTH = IQ_DEPTH_DEFAULT
) (
   input  logic                          clock,
   input  logic                          reset,
   input  DISPATCH_PACKET [N_WAY-1:0]    fetch_packet,
   input  logic [N_WAY-1:0]              fetch_branch,
   output logic                          fetch_ready,
   output DISPATCH_PACKET [N_WAY-1:0]    dispatch_packet,
   output logic [N_WAY-1:0]              branch_inst,
   output logic [$clog2(N_WAY):0]        dispatch_num,
   input  logic [N_WAY-1:0]              dispatched,
   input  logic                          branch_haz,
   output logic [$clog2(IQ_DEPTH):0]     iq_count
);

   localparam int PTR_W = $clog2(IQ_DEPTH);
   localparam int CNT_W = PTR_W + 1;
   localparam int LN_W  = $clog2(N_WAY) + 1;

   IQ_ENTRY          entries_q [IQ_DEPTH];
   logic [PTR_W-1:0] head_q, head_d;
   logic [PTR_W-1:0] tail_q, tail_d;
   logic [CNT_W-1:0] count_q, count_d;

   logic [N_WAY-1:0] pres_valid;
   logic [N_WAY-1:0] push_mask;
   logic [N_WAY-1:0] pop_mask;
   logic [LN_W-1:0]  push_n;
   logic [LN_W-1:0]  pop_n;

   // Ready looks only at the registered count so no input reaches any output.
   assign fetch_ready  = (CNT_W'(IQ_DEPTH) - count_q) >= CNT_W'(N_WAY);
   assign dispatch_num = (count_q >= CNT_W'(N_WAY)) ? LN_W'(N_WAY) : LN_W'(count_q);
   assign iq_count     = count_q;

   generate
      for (genvar gi = 0; gi < N_WAY; gi++) begin : g_lane
         logic [PTR_W-1:0] rd_idx;
         // Power-of-two depth: the pointer wraps by truncation.
         assign rd_idx          = head_q + PTR_W'(gi);
         assign pres_valid[gi]  = count_q > CNT_W'(gi);
         assign dispatch_packet[gi] = pres_valid[gi] ? entries_q[rd_idx].pkt : '0;
         assign branch_inst[gi] = pres_valid[gi] & entries_q[rd_idx].branch;
         assign push_mask[gi]   = fetch_packet[gi].valid & fetch_ready;
         assign pop_mask[gi]    = dispatched[gi] & pres_valid[gi];
      end
   endgenerate

   lsb_ones_count #(.N(N_WAY)) u_push_cnt (
      .bits_i  (push_mask),
      .count_o (push_n)
   );

   lsb_ones_count #(.N(N_WAY)) u_pop_cnt (
      .bits_i  (pop_mask),
      .count_o (pop_n)
   );

   always_comb begin
      head_d  = head_q + PTR_W'(pop_n);
      tail_d  = tail_q + PTR_W'(push_n);
      count_d = count_q + CNT_W'(push_n) - CNT_W'(pop_n);
      if (branch_haz) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
      end
   end

   // Payload storage carries no reset; occupancy alone decides what is visible.
   always_ff @(posedge clock) begin
      if (!branch_haz) begin
         for (int i = 0; i < N_WAY; i++) begin
            if (LN_W'(i) < push_n) begin
               entries_q[tail_q + PTR_W'(i)] <= '{pkt: fetch_packet[i], branch: fetch_branch[i]};
            end
         end
      end
   end

endmodule
